// File: rtl/stream_compare_multi.sv
// Multi-stream comparator: channel 0 is golden, channels 1..N_CHAN-1 are checked against it
// and the results are counted in IPIF registers. Define STREAM_COMPARE_FIRST_MISMATCH_EN to capture FIRSTERR.
module stream_compare_multi #(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int N_CHAN             = 4,
  parameter int DATA_WIDTH         = 32,
  parameter int N_REG              = 12
) (
  input  logic                            clk,
  input  logic                            areset,
  input  logic [N_CHAN*DATA_WIDTH-1:0]    S_AXIS_TDATA,
  input  logic [N_CHAN-1:0]               S_AXIS_TVALID,
  output logic [N_CHAN-1:0]               S_AXIS_TREADY,
  input  logic                            IPIF_Bus2IP_resetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   IPIF_Bus2IP_Addr,
  input  logic                            IPIF_Bus2IP_RNW,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] IPIF_Bus2IP_BE,
  input  logic                            IPIF_Bus2IP_CS,
  input  logic [N_REG-1:0]                IPIF_Bus2IP_RdCE,
  input  logic [N_REG-1:0]                IPIF_Bus2IP_WrCE,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   IPIF_Bus2IP_Data,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   IPIF_IP2Bus_Data,
  output logic                            IPIF_IP2Bus_WrAck,
  output logic                            IPIF_IP2Bus_RdAck,
  output logic                            IPIF_IP2Bus_Error
);

  localparam int unsigned CNT_W = 32;

  logic                         enable;
  logic [DATA_WIDTH-1:0]        mask;
  logic                         stage_valid;
  logic [N_CHAN*DATA_WIDTH-1:0] stage_data;
  logic [CNT_W-1:0]             wordcnt;
  logic [N_CHAN-1:1]            flags;
  logic [CNT_W-1:0]             errcnt [1:N_CHAN-1];
  logic [CNT_W-1:0]             firsterr;
  logic [N_CHAN-1:0]            mism;
  logic                         accept;
  logic                         clear;
  logic [CNT_W-1:0]             regs [N_REG];
  logic [CNT_W-1:0]             rd_mux;
  logic                         unused_ok;

  assign unused_ok = ^{IPIF_Bus2IP_resetn, IPIF_Bus2IP_Addr, IPIF_Bus2IP_RNW,
                       IPIF_Bus2IP_BE, IPIF_Bus2IP_CS, IPIF_Bus2IP_Data};

  assign accept        = enable & (&S_AXIS_TVALID);
  assign S_AXIS_TREADY = {N_CHAN{accept}};
  assign clear         = IPIF_Bus2IP_WrCE[0] & IPIF_Bus2IP_Data[1];

  // Per-channel masked mismatch of the staged beat; channel 0 never mismatches itself
  always_comb begin
    mism = '0;
    for (int k = 1; k < N_CHAN; k++)
      mism[k] = |((stage_data[0 +: DATA_WIDTH] ^ stage_data[k*DATA_WIDTH +: DATA_WIDTH]) & mask);
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      stage_valid <= 1'b0;
      stage_data  <= '0;
    end else begin
      stage_valid <= accept;
      if (accept) stage_data <= S_AXIS_TDATA;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      enable <= 1'b0;
      mask   <= '1;
    end else begin
      if (IPIF_Bus2IP_WrCE[0]) enable <= IPIF_Bus2IP_Data[0];
      if (IPIF_Bus2IP_WrCE[1]) mask   <= IPIF_Bus2IP_Data[DATA_WIDTH-1:0];
    end
  end

  // Saturating counters; a clear on the same edge discards the staged update
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wordcnt <= '0;
      flags   <= '0;
      for (int k = 1; k < N_CHAN; k++) errcnt[k] <= '0;
    end else if (clear) begin
      wordcnt <= '0;
      flags   <= '0;
      for (int k = 1; k < N_CHAN; k++) errcnt[k] <= '0;
    end else if (stage_valid) begin
      if (wordcnt != '1) wordcnt <= wordcnt + CNT_W'(1);
      for (int k = 1; k < N_CHAN; k++) begin
        if (mism[k]) begin
          flags[k] <= 1'b1;
          if (errcnt[k] != '1) errcnt[k] <= errcnt[k] + CNT_W'(1);
        end
      end
    end
  end

`ifdef STREAM_COMPARE_FIRST_MISMATCH_EN
  logic [2:0] low_idx;

  always_comb begin
    low_idx = 3'd0;
    for (int k = N_CHAN-1; k >= 1; k--)
      if (mism[k]) low_idx = 3'(k);
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset)
      firsterr <= '0;
    else if (clear)
      firsterr <= '0;
    else if (stage_valid && (|mism) && !firsterr[31])
      firsterr <= {1'b1, low_idx, wordcnt[27:0]};
  end
`else
  assign firsterr = '0;
`endif

  // Register read view and combinational read mux
  always_comb begin
    for (int i = 0; i < N_REG; i++) regs[i] = '0;
    regs[0] = {31'd0, enable};
    regs[1] = CNT_W'(mask);
    regs[2] = wordcnt;
    regs[3] = CNT_W'({flags, 1'b0});
    for (int k = 1; k < N_CHAN; k++) regs[k+3] = errcnt[k];
    regs[11] = firsterr;
    rd_mux = '0;
    for (int i = N_REG-1; i >= 0; i--)
      if (IPIF_Bus2IP_RdCE[i]) rd_mux = regs[i];
  end

  assign IPIF_IP2Bus_Data  = C_S_AXI_DATA_WIDTH'(rd_mux);
  assign IPIF_IP2Bus_WrAck = |IPIF_Bus2IP_WrCE;
  assign IPIF_IP2Bus_RdAck = |IPIF_Bus2IP_RdCE;
  assign IPIF_IP2Bus_Error = 1'b0;

endmodule

// File: doc/stream_compare_multi.md
STREAM_COMPARE_MULTI -- requirements
Module: stream_compare_multi

Interface
REQ-001 Parameter C_S_AXI_ADDR_WIDTH, default 32, IPIF address width.
REQ-002 Parameter C_S_AXI_DATA_WIDTH, default 32, IPIF data width.
REQ-003 Parameter N_CHAN, default 4, number of compared streams; legal range 2..8.
REQ-004 Parameter DATA_WIDTH, default 32, stream word width; legal range 1..32.
REQ-005 Parameter N_REG, default 12, number of IPIF registers; fixed at 12.
REQ-006 Port clk, input, 1, the single clock for all logic.
REQ-007 Port areset, input, 1, asynchronous active-high reset.
REQ-008 Port S_AXIS_TDATA, input, N_CHAN*DATA_WIDTH, channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 Port S_AXIS_TVALID, input, N_CHAN, per-channel valid.
REQ-010 Port S_AXIS_TREADY, output, N_CHAN, per-channel ready.
REQ-011 IPIF ports IPIF_Bus2IP_resetn, _Addr, _RNW, _BE, _CS, _RdCE[N_REG], _WrCE[N_REG], _Data, IP2Bus_Data, IP2Bus_WrAck, IP2Bus_RdAck, IP2Bus_Error; resetn, Addr, RNW, BE and CS are unused.

Function
REQ-012 Channel 0 is the golden stream; channels 1..N_CHAN-1 are each compared against it.
REQ-013 Accept = CTRL.enable AND all S_AXIS_TVALID bits high; S_AXIS_TREADY is all-ones exactly when accept is high, otherwise all-zeros.
REQ-014 On an accept edge the block registers all channel words into a one-deep compare stage, with stage-valid set.
REQ-015 On the next edge a registered stage updates the counters: WORDCNT+1; for each k>=1 with (ch0 XOR chk) AND MASK nonzero, ERRCNT[k]+1 and FLAGS[k] set.
REQ-016 Counter update latency from the accept edge is one cycle; a readback is valid from two edges after accept.
REQ-017 Throughput is one beat per cycle, with no bubbles between back-to-back accepts.
REQ-018 All counters are 32 bits and saturate at 0xFFFFFFFF; they never wrap.
REQ-019 Register map (RdCE/WrCE bit i selects reg i):
- 0: CTRL (bit0 enable, bit1 clear).
- 1: MASK, low DATA_WIDTH bits.
- 2: WORDCNT.
- 3: FLAGS, sticky, bit k per channel.
- 4..10: ERRCNT[1..7].
- 11: FIRSTERR.
- Unused or nonexistent channel registers read 0.
REQ-020 Only CTRL and MASK are writable, always as a full word (BE is ignored); writes to other registers are ignored.
REQ-021 IP2Bus_WrAck = OR(WrCE) and IP2Bus_RdAck = OR(RdCE), both combinational; IP2Bus_Data is a combinational mux of the selected register and is 0 when no RdCE bit is set; IP2Bus_Error is always 0.
REQ-022 Writing CTRL bit1=1 clears WORDCNT, FLAGS, all ERRCNT and FIRSTERR on that edge; bit1 is self-clearing and reads 0.
REQ-023 A counter update on the same edge as a clear is discarded: clear wins.
REQ-024 Deasserting enable drops TREADY on the next cycle; a beat already in the compare stage is still counted.

Reset
REQ-025 areset asynchronously resets the block to:
- CTRL = 0 (disabled).
- MASK = all ones.
- All counters, FLAGS and FIRSTERR = 0.
- Stage-valid = 0.
- S_AXIS_TREADY = 0.
REQ-026 A beat held in the compare stage when areset is asserted is discarded; areset overrides any concurrent IPIF write.

Configuration
REQ-027 Macro STREAM_COMPARE_FIRST_MISMATCH_EN enables FIRSTERR capture:
- Capture happens on the first mismatch after reset or clear.
- Bit31 = valid.
- Bits[30:28] = lowest mismatching channel index.
- Bits[27:0] = WORDCNT[27:0] before increment.
- FIRSTERR holds until reset or clear.
REQ-028 Without the macro, FIRSTERR reads 0 and no capture logic is instantiated.

Verification
REQ-029 N_CHAN=2, ch0=0x12345678, ch1=0x12345679, both valid, enable written at t0 -> after 10 accepts WORDCNT=10, ERRCNT[1]=10, FLAGS=0x2.
REQ-030 Same stimulus, MASK=0xFFFFFFFE -> WORDCNT increments and ERRCNT[1] stays 0; write CTRL=0x3 -> all counters read 0 on the next cycle and counting resumes.
REQ-031 N_CHAN=4, ch2 TVALID low -> TREADY=0000 and counters frozen; raise ch2 valid -> TREADY=1111 on the same cycle.
REQ-032 Mismatch on the clear edge -> counter reads 0; areset mid-stream with a staged beat -> all registers at reset values and the staged beat not counted.
REQ-033 With macro: first ch3 mismatch at word 5 -> FIRSTERR=0xB0000005 and unchanged by later mismatches; without macro -> FIRSTERR=0.
